// File: rtl/sfp_seq.sv
// ---------------------------------------------------------------------------
// sfp_seq -- row sequencer for a two-core softmax pipeline.
//
// For each row of a job: read the partial sum from psum memory, have the
// softmax row accumulate it, let the two-stage sum pipeline settle,
// handshake the local sum with the peer core, issue the divide, wait for
// the divide-complete flag, then write the result back to the same address
// (the external fifo is popped in the same cycle).
//
// Parameters
//   addr_bw  : psum/output memory address width
//   len_bw   : row-count width
//   timeout  : SYNC/WAIT watchdog limit in cycles (only with the macro)
//
// Ports
//   clk, reset            : single rising-edge clock, synchronous active-high reset
//   start                 : one-cycle job launch pulse (honoured only in IDLE)
//   base_addr, num_rows   : job description, captured at launch
//   mem_rd, mem_addr      : psum read strobe / read-and-write address
//   acc, div              : accumulate / divide commands to the softmax row
//   valid                 : divide-complete flag from the softmax row
//   sync_out, sync_in     : local / peer sum-ready handshake
//   out_wr, fifo_ext_rd   : result write strobe and identical fifo pop
//   busy, done, err       : job active, completion pulse, sticky timeout flag
//
// Configuration macro
//   SFP_SEQ_TIMEOUT_EN : when defined, a watchdog aborts a job that sits in
//                        SYNC or WAIT for `timeout` consecutive cycles and
//                        sets the sticky err flag. When undefined, those
//                        states wait indefinitely and err is tied to 0.
//
// All outputs are registered: each output is loaded on the edge that enters
// the state in which it must be visible.
// ---------------------------------------------------------------------------
module sfp_seq #(
    parameter int addr_bw = 11,
    parameter int len_bw  = 6,
    parameter int timeout = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] base_addr,
    input  logic [len_bw-1:0]  num_rows,
    output logic               mem_rd,
    output logic [addr_bw-1:0] mem_addr,
    output logic               acc,
    output logic               div,
    input  logic               valid,
    output logic               sync_out,
    input  logic               sync_in,
    output logic               out_wr,
    output logic               fifo_ext_rd,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD     = 4'd1,
        ACC    = 4'd2,
        SETTLE = 4'd3,
        SYNC   = 4'd4,
        DIV    = 4'd5,
        WAIT   = 4'd6,
        WR     = 4'd7,
        DONE   = 4'd8
    } state_t;

    state_t             state;
    logic [addr_bw-1:0] base_r;
    logic [len_bw-1:0]  rows_r;
    logic [len_bw-1:0]  row_cnt;
    // Shared 2-cycle counter for SETTLE and the valid-blanking window in WAIT.
    logic               sub_cnt;

`ifdef SFP_SEQ_TIMEOUT_EN
    localparam int tmo_w = (timeout < 2) ? 1 : $clog2(timeout);
    logic [tmo_w-1:0] tmo_cnt;
    logic             err_r;
    logic             tmo_hit;

    assign err     = err_r;
    // The current cycle is the timeout-th consecutive cycle in SYNC/WAIT.
    assign tmo_hit = (tmo_cnt == tmo_w'(timeout - 1));
`else
    assign err = 1'b0;
`endif

    // Sequencer FSM: state, job registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            base_r      <= {addr_bw{1'b0}};
            rows_r      <= {len_bw{1'b0}};
            row_cnt     <= {len_bw{1'b0}};
            sub_cnt     <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= {addr_bw{1'b0}};
            acc         <= 1'b0;
            div         <= 1'b0;
            sync_out    <= 1'b0;
            out_wr      <= 1'b0;
            fifo_ext_rd <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef SFP_SEQ_TIMEOUT_EN
            tmo_cnt     <= {tmo_w{1'b0}};
            err_r       <= 1'b0;
`endif
        end else begin
            // Strobes default low; the entered state re-asserts what it needs.
            mem_rd      <= 1'b0;
            mem_addr    <= {addr_bw{1'b0}};
            acc         <= 1'b0;
            div         <= 1'b0;
            sync_out    <= 1'b0;
            out_wr      <= 1'b0;
            fifo_ext_rd <= 1'b0;
            done        <= 1'b0;

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        base_r  <= base_addr;
                        rows_r  <= num_rows;
                        row_cnt <= {len_bw{1'b0}};
                        busy    <= 1'b1;
                        if (num_rows == {len_bw{1'b0}}) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= RD;
                            mem_rd   <= 1'b1;
                            mem_addr <= base_addr;
                        end
                    end
                end

                RD: begin
                    state <= ACC;
                    acc   <= 1'b1;
                end

                ACC: begin
                    state   <= SETTLE;
                    sub_cnt <= 1'b0;
                end

                SETTLE: begin
                    if (sub_cnt) begin
                        state    <= SYNC;
                        sync_out <= 1'b1;
`ifdef SFP_SEQ_TIMEOUT_EN
                        tmo_cnt  <= {tmo_w{1'b0}};
`endif
                    end else begin
                        sub_cnt <= 1'b1;
                    end
                end

                SYNC: begin
                    if (sync_in) begin
                        state <= DIV;
                        div   <= 1'b1;
`ifdef SFP_SEQ_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err_r <= 1'b1;
`endif
                    end else begin
                        sync_out <= 1'b1;
`ifdef SFP_SEQ_TIMEOUT_EN
                        tmo_cnt  <= tmo_cnt + tmo_w'(1);
`endif
                    end
                end

                DIV: begin
                    state   <= WAIT;
                    sub_cnt <= 1'b0;
`ifdef SFP_SEQ_TIMEOUT_EN
                    tmo_cnt <= {tmo_w{1'b0}};
`endif
                end

                // valid is blanked during DIV and the first WAIT cycle because
                // the softmax row's flag is registered and may still be stale.
                WAIT: begin
                    if (sub_cnt && valid) begin
                        state       <= WR;
                        out_wr      <= 1'b1;
                        fifo_ext_rd <= 1'b1;
                        mem_addr    <= base_r + addr_bw'(row_cnt);
`ifdef SFP_SEQ_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        state <= DONE;
                        done  <= 1'b1;
                        err_r <= 1'b1;
`endif
                    end else begin
                        sub_cnt <= 1'b1;
`ifdef SFP_SEQ_TIMEOUT_EN
                        tmo_cnt <= tmo_cnt + tmo_w'(1);
`endif
                    end
                end

                WR: begin
                    row_cnt <= row_cnt + len_bw'(1);
                    if (row_cnt == rows_r - len_bw'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= RD;
                        mem_rd   <= 1'b1;
                        mem_addr <= base_r + addr_bw'(row_cnt + len_bw'(1));
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
